// File: rtl/flag_stuck_monitor.sv
// flag_stuck_monitor
//   Watches two 1-bit flag fields and declares a channel "stuck" once it
//   has presented STUCK_LIMIT identical consecutive samples. Each channel
//   also keeps a saturating count of how often its flag toggled.
//
//   Optional feature macro: FLAG_MON_TOGGLE_CNT_EN
//     defined   -> toggle counters are implemented
//     undefined -> no counter registers, toggle_cnt_a/b read as 0
//
//   Parameters
//     STUCK_LIMIT  identical samples that declare stuck (2..255)
//     CNT_W        toggle counter width (2..16)
//
//   Ports
//     clk            single clock, rising edge
//     rst            synchronous active-high reset
//     flag_a/flag_b  flag inputs, sampled every cycle
//     clear          one-cycle restart of monitoring (rst has priority)
//     stuck_a/b      high while the channel is in STUCK
//     stuck_pulse    one-cycle strobe when any channel enters STUCK
//     toggle_cnt_a/b saturating toggle counts
//
//   state    | meaning
//   ST_IDLE  | no valid sample yet, next edge captures the flag
//   ST_RUN   | tracking a run of identical samples
//   ST_STUCK | run length reached STUCK_LIMIT
module flag_stuck_monitor #(
    parameter int STUCK_LIMIT = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flag_a,
    input  logic             flag_b,
    input  logic             clear,
    output logic             stuck_a,
    output logic             stuck_b,
    output logic             stuck_pulse,
    output logic [CNT_W-1:0] toggle_cnt_a,
    output logic [CNT_W-1:0] toggle_cnt_b
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_STUCK = 2'd2;

    localparam logic [7:0] LIMIT   = 8'(STUCK_LIMIT);
    localparam logic [7:0] RUN_ONE = 8'd1;

    // Index 0 is channel A, index 1 is channel B.
    logic [1:0] flag_in;
    logic [1:0] state_q [2];
    logic [1:0] state_d [2];
    logic       prev_q  [2];
    logic       prev_d  [2];
    logic [7:0] run_q   [2];
    logic [7:0] run_d   [2];
    logic [1:0] tgl;
    logic       enter_stuck;
    logic       pulse_q;

    assign flag_in = {flag_b, flag_a};

    always_comb begin
        enter_stuck = 1'b0;
        tgl         = 2'b00;
        for (int i = 0; i < 2; i++) begin
            state_d[i] = state_q[i];
            prev_d[i]  = prev_q[i];
            run_d[i]   = run_q[i];
            case (state_q[i])
                ST_IDLE: begin
                    prev_d[i]  = flag_in[i];
                    run_d[i]   = RUN_ONE;
                    state_d[i] = ST_RUN;
                end
                ST_RUN: begin
                    if (flag_in[i] == prev_q[i]) begin
                        run_d[i] = run_q[i] + RUN_ONE;
                        if (run_q[i] + RUN_ONE == LIMIT) begin
                            state_d[i] = ST_STUCK;
                        end
                    end else begin
                        prev_d[i] = flag_in[i];
                        run_d[i]  = RUN_ONE;
                        tgl[i]    = 1'b1;
                    end
                end
                ST_STUCK: begin
                    // Run length is frozen at the limit while stuck.
                    if (flag_in[i] != prev_q[i]) begin
                        prev_d[i]  = flag_in[i];
                        run_d[i]   = RUN_ONE;
                        state_d[i] = ST_RUN;
                        tgl[i]     = 1'b1;
                    end
                end
                default: begin
                    prev_d[i]  = 1'b0;
                    run_d[i]   = 8'd0;
                    state_d[i] = ST_IDLE;
                end
            endcase
            if (state_d[i] == ST_STUCK && state_q[i] != ST_STUCK) begin
                enter_stuck = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= ST_IDLE;
                prev_q[i]  <= 1'b0;
                run_q[i]   <= 8'd0;
            end
            pulse_q <= 1'b0;
        end else if (clear) begin
            // The current flag becomes the first sample of a fresh run.
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= ST_RUN;
                prev_q[i]  <= flag_in[i];
                run_q[i]   <= RUN_ONE;
            end
            pulse_q <= 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                state_q[i] <= state_d[i];
                prev_q[i]  <= prev_d[i];
                run_q[i]   <= run_d[i];
            end
            pulse_q <= enter_stuck;
        end
    end

    assign stuck_a     = (state_q[0] == ST_STUCK);
    assign stuck_b     = (state_q[1] == ST_STUCK);
    assign stuck_pulse = pulse_q;

`ifdef FLAG_MON_TOGGLE_CNT_EN
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] cnt_q [2];

    always_ff @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (rst || clear) begin
                cnt_q[i] <= '0;
            end else if (tgl[i] && cnt_q[i] != CNT_MAX) begin
                cnt_q[i] <= cnt_q[i] + CNT_ONE;
            end
        end
    end

    assign toggle_cnt_a = cnt_q[0];
    assign toggle_cnt_b = cnt_q[1];
`else
    logic unused_tgl;

    assign unused_tgl   = ^tgl;
    assign toggle_cnt_a = '0;
    assign toggle_cnt_b = '0;
`endif

endmodule

// File: tb/tb_flag_stuck_monitor.sv
// Testbench for flag_stuck_monitor (STUCK_LIMIT=4, CNT_W=8).
// Stimulus pushes hand-computed expectations into a queue; a monitor on the
// falling edge pops and compares them against the DUT outputs.
module tb_flag_stuck_monitor;

    logic       clk;
    logic       rst;
    logic       flag_a;
    logic       flag_b;
    logic       clear;
    logic       stuck_a;
    logic       stuck_b;
    logic       stuck_pulse;
    logic [7:0] toggle_cnt_a;
    logic [7:0] toggle_cnt_b;

    int total = 0;
    int bad   = 0;

    typedef struct {
        string name;
        logic  sa;
        logic  sb;
        logic  sp;
        int    ca;
        int    cb;
    } exp_t;

    exp_t exp_q[$];

    flag_stuck_monitor #(
        .STUCK_LIMIT(4),
        .CNT_W      (8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .flag_a      (flag_a),
        .flag_b      (flag_b),
        .clear       (clear),
        .stuck_a     (stuck_a),
        .stuck_b     (stuck_b),
        .stuck_pulse (stuck_pulse),
        .toggle_cnt_a(toggle_cnt_a),
        .toggle_cnt_b(toggle_cnt_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int exp_cnt(input int v);
`ifdef FLAG_MON_TOGGLE_CNT_EN
        return v;
`else
        return 0;
`endif
    endfunction

    task automatic step(input logic a, input logic b, input logic c, input logic r);
        flag_a = a;
        flag_b = b;
        clear  = c;
        rst    = r;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic sa, input logic sb,
                       input logic sp, input int ca, input int cb);
        exp_t e;
        e.name = name;
        e.sa   = sa;
        e.sb   = sb;
        e.sp   = sp;
        e.ca   = exp_cnt(ca);
        e.cb   = exp_cnt(cb);
        exp_q.push_back(e);
    endtask

    // Monitor: compares every pending expectation at the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            while (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                total++;
                if (stuck_a !== e.sa) begin
                    bad++;
                    $display("FAIL %s stuck_a: got %b want %b", e.name, stuck_a, e.sa);
                end
                total++;
                if (stuck_b !== e.sb) begin
                    bad++;
                    $display("FAIL %s stuck_b: got %b want %b", e.name, stuck_b, e.sb);
                end
                total++;
                if (stuck_pulse !== e.sp) begin
                    bad++;
                    $display("FAIL %s stuck_pulse: got %b want %b", e.name, stuck_pulse, e.sp);
                end
                total++;
                if ($isunknown(toggle_cnt_a) || int'(toggle_cnt_a) != e.ca) begin
                    bad++;
                    $display("FAIL %s toggle_cnt_a: got %0d want %0d", e.name, toggle_cnt_a, e.ca);
                end
                total++;
                if ($isunknown(toggle_cnt_b) || int'(toggle_cnt_b) != e.cb) begin
                    bad++;
                    $display("FAIL %s toggle_cnt_b: got %0d want %0d", e.name, toggle_cnt_b, e.cb);
                end
            end
        end
    end

    initial begin
        logic v;
        int   c;
        rst    = 1'b1;
        clear  = 1'b0;
        flag_a = 1'b0;
        flag_b = 1'b0;

        // Reset, then both flags held: stuck after the 4th sampling edge.
        step(0, 0, 0, 1);
        chk("reset", 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            step(0, 1, 0, 0);
            chk("hold_both", k >= 4, k >= 4, k == 4, 0, 0);
        end

        // Clear, then 9 alternating samples on both channels.
        step(0, 1, 1, 0);
        chk("clear1", 0, 0, 0, 0, 0);
        for (int k = 1; k <= 9; k++) begin
            v = (k % 2 == 1);
            step(v, ~v, 0, 0);
            chk("alternate", 0, 0, 0, k, k);
        end

        // Hold a=1, b=0: run started at 1, three more edges reach the limit.
        for (int k = 1; k <= 4; k++) begin
            step(1, 0, 0, 0);
            chk("hold_after_alt", k >= 3, k >= 3, k == 3, 9, 9);
        end
        step(0, 0, 0, 0);
        chk("flip_a_unstick", 0, 1, 0, 10, 9);
        for (int k = 1; k <= 3; k++) begin
            step(0, 0, 0, 0);
            chk("restick_a", k == 3, 1, k == 3, 10, 9);
        end

        // Build count 5, then clear coincident with a flip on flag_b.
        step(0, 0, 1, 0);
        chk("clear2", 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            v = (k % 2 == 1);
            step(v, v, 0, 0);
            chk("count_to_5", 0, 0, 0, k, k);
        end
        step(1, 0, 1, 0);
        chk("clear_with_flip", 0, 0, 0, 0, 0);
        step(1, 0, 0, 0);
        chk("after_clear_flip", 0, 0, 0, 0, 0);

        // Reset mid-run discards a 3-sample history.
        step(1, 0, 0, 1);
        chk("reset2", 0, 0, 0, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            v = (k % 2 == 1);
            step(1, v, 0, 0);
            chk("pre_reset_run", 0, 0, 0, 0, k - 1);
        end
        step(1, 0, 0, 1);
        chk("reset_mid_run", 0, 0, 0, 0, 0);
        for (int k = 1; k <= 5; k++) begin
            v = (k % 2 == 1);
            step(1, v, 0, 0);
            chk("post_reset_run", k >= 4, 0, k == 4, 0, k - 1);
        end

        // Rst and clear together: rst wins (channels IDLE, a=1 needs 4 samples).
        step(1, 1, 1, 1);
        chk("rst_and_clear", 0, 0, 0, 0, 0);
        for (int k = 1; k <= 4; k++) begin
            step(1, 1, 0, 0);
            chk("after_rst_clear", k >= 4, k >= 4, k == 4, 0, 0);
        end

        // Saturation: 300 toggles on both channels.
        step(1, 0, 1, 0);
        chk("clear3", 0, 0, 0, 0, 0);
        for (int k = 1; k <= 300; k++) begin
            v = (k % 2 == 0);
            step(v, ~v, 0, 0);
            c = (k > 255) ? 255 : k;
            if (k == 1 || k == 254 || k == 255 || k == 256 || k == 300) begin
                chk("saturate", 0, 0, 0, c, c);
            end
        end
        for (int k = 1; k <= 3; k++) begin
            step(1, 0, 0, 0);
            chk("stuck_at_sat", k == 3, k == 3, k == 3, 255, 255);
        end
        step(0, 0, 0, 0);
        chk("flip_at_sat", 0, 1, 0, 255, 255);

        @(negedge clk);
        @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/flag_stuck_monitor.md
FLAG_STUCK_MONITOR -- requirements
Module: flag_stuck_monitor

Interface
REQ-001 SHALL have parameter STUCK_LIMIT, default 4: consecutive identical samples that declare a flag stuck; legal range 2..255.
REQ-002 SHALL have parameter CNT_W, default 8: toggle counter width; legal range 2..16.
REQ-003 SHALL have port clk, input, 1: single clock; all state changes on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port flag_a, input, 1: flag field of the first interface instance, sampled every cycle.
REQ-006 SHALL have port flag_b, input, 1: flag field of the second interface instance, sampled every cycle.
REQ-007 SHALL have port clear, input, 1: single-cycle request to restart monitoring.
REQ-008 SHALL have ports stuck_a and stuck_b, output, 1 each: registered channel-stuck status.
REQ-009 SHALL have port stuck_pulse, output, 1: one-cycle strobe when either channel enters STUCK.
REQ-010 SHALL have ports toggle_cnt_a and toggle_cnt_b, output, CNT_W each: saturating toggle counts.

Function
REQ-011 SHALL run two identical, independent channel FSMs (A on flag_a, B on flag_b), each holding prev, run_len (8 bit), state.
REQ-012 SHALL use states IDLE (no valid sample), RUN, STUCK.
REQ-013 IDLE: next edge SHALL capture flag into prev, set run_len=1, go to RUN; no toggle counted.
REQ-014 RUN, flag==prev: run_len SHALL increment; when the incremented value equals STUCK_LIMIT, go to STUCK.
REQ-015 RUN, flag!=prev: prev<=flag, run_len<=1, toggle count +1.
REQ-016 STUCK, flag==prev: SHALL hold state; run_len SHALL not increment past STUCK_LIMIT.
REQ-017 STUCK, flag!=prev: SHALL return to RUN with run_len=1, prev<=flag, toggle count +1.
REQ-018 stuck_x SHALL be 1 exactly while channel x is in STUCK; it asserts in the cycle after the edge on which the STUCK_LIMIT-th identical sample is taken.
REQ-019 stuck_pulse SHALL be 1 for exactly one cycle when at least one channel transitions into STUCK on the preceding edge; simultaneous entry of both channels SHALL give one pulse.
REQ-020 Toggle counters SHALL saturate at 2^CNT_W-1 and never wrap.
REQ-021 clear SHALL, on its edge, zero both toggle counters, set both channels to RUN with prev<=current flag and run_len=1, and deassert stuck_a/stuck_b/stuck_pulse.
REQ-022 clear and a flag change on the same edge: clear SHALL win; the change is not counted.
REQ-023 rst and clear together: rst SHALL win.

Reset
REQ-024 On rst high at an edge: both channels IDLE, prev=0, run_len=0, toggle counters 0, stuck_a=stuck_b=stuck_pulse=0.
REQ-025 Reset mid-run SHALL discard all history; STUCK_LIMIT fresh samples after deassertion are required to re-declare stuck.

Configuration
REQ-026 Macro FLAG_MON_TOGGLE_CNT_EN defined: toggle counters SHALL be implemented per REQ-015/017/020/021.
REQ-027 Macro undefined: no counter registers; toggle_cnt_a/toggle_cnt_b SHALL be tied to 0; ports unchanged; stuck behaviour identical.

Verification (STUCK_LIMIT=4, CNT_W=8, macro defined unless noted)
REQ-028 Release rst, hold flag_a=0, flag_b=1 -> stuck_a and stuck_b rise in the cycle after the 4th sampling edge; stuck_pulse high exactly one cycle.
REQ-029 flag_a alternates each cycle for 10 samples -> stuck_a stays 0; toggle_cnt_a=9.
REQ-030 flag_a stuck (stuck_a=1), then flag_a flips -> stuck_a 0 the cycle after the flip is sampled; toggle_cnt_a +1; 4 more identical samples re-assert stuck_a with a new stuck_pulse.
REQ-031 clear coincident with flag_b flip, toggle_cnt_b=5 -> toggle_cnt_b=0, stuck_b=0, flip not counted.
REQ-032 3 identical samples on flag_a, rst for 1 cycle, then same value held -> stuck_a asserts only after 4 new samples (1 IDLE capture + 3).
REQ-033 300 toggles on flag_a -> toggle_cnt_a=255; with macro undefined -> toggle_cnt_a=0 throughout while stuck behaviour matches.
